// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter and transaction sequencer in front of a
// single-byte I2C master core, with retry, backoff and watchdog abort.
module i2c_master_arbiter #(
   parameter int NREQ      = 4,
   parameter int MAX_RETRY = 2,
   parameter int BACKOFF   = 8,
   parameter int TIMEOUT   = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [7*NREQ-1:0] req_addr,
   input  logic [NREQ-1:0]   req_rw,
   input  logic [8*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              err,
   output logic [7:0]        rdata,
   output logic              m_start,
   output logic [6:0]        m_addr,
   output logic              m_rw,
   output logic [7:0]        m_wdata,
   output logic              m_abort,
   input  logic              m_done,
   input  logic              m_error,
   input  logic [7:0]        m_rdata
);

   localparam int PW = $clog2(NREQ);
   localparam int TW = $clog2(TIMEOUT);
   localparam int BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_BACKOFF,
      S_COMPLETE
   } state_t;

   state_t         state;
   logic [PW-1:0]  ptr;
   logic [PW-1:0]  cur;
   logic [TW-1:0]  timer;
   logic [BW-1:0]  bcnt;
   logic [RW-1:0]  retry;

   logic [PW-1:0]  pick;
   logic           any;

   // Rotating priority search starting just after the last winner
   always_comb begin
      int j;
      pick = '0;
      any  = 1'b0;
      j    = 0;
      for (int k = 1; k <= NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!any && req[j]) begin
            any  = 1'b1;
            pick = PW'(j);
         end
      end
   end

   // Transaction sequencer: grant, issue, wait, retry and completion
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         ptr     <= PW'(NREQ - 1);
         cur     <= '0;
         timer   <= '0;
         bcnt    <= '0;
         retry   <= '0;
         gnt     <= '0;
         done    <= '0;
         err     <= 1'b0;
         rdata   <= '0;
         m_start <= 1'b0;
         m_addr  <= '0;
         m_rw    <= 1'b0;
         m_wdata <= '0;
         m_abort <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any) begin
                  gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                  cur     <= pick;
                  m_addr  <= req_addr[7*pick +: 7];
                  m_rw    <= req_rw[pick];
                  m_wdata <= req_wdata[8*pick +: 8];
                  m_start <= 1'b1;
                  retry   <= '0;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               m_start <= 1'b0;
               timer   <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               timer <= timer + 1'b1;
               if (m_done) begin
                  if (!m_error) begin
                     rdata <= m_rw ? m_rdata : 8'h00;
                     err   <= 1'b0;
                     done  <= gnt;
                     state <= S_COMPLETE;
                  end else if (retry < RW'(MAX_RETRY)) begin
                     retry <= retry + 1'b1;
                     bcnt  <= '0;
                     state <= S_BACKOFF;
                  end else begin
                     err   <= 1'b1;
                     rdata <= 8'h00;
                     done  <= gnt;
                     state <= S_COMPLETE;
                  end
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  m_abort <= 1'b1;
                  err     <= 1'b1;
                  rdata   <= 8'h00;
                  done    <= gnt;
                  state   <= S_COMPLETE;
               end
            end
            S_BACKOFF: begin
               if (bcnt == BW'(BACKOFF - 1)) begin
                  m_start <= 1'b1;
                  state   <= S_ISSUE;
               end else begin
                  bcnt <= bcnt + 1'b1;
               end
            end
            S_COMPLETE: begin
               ptr     <= cur;
               gnt     <= '0;
               done    <= '0;
               err     <= 1'b0;
               rdata   <= 8'h00;
               m_abort <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed and randomized bench for i2c_master_arbiter with a
// transaction-level model of grant order, retries and timeouts.
module tb_i2c_master_arbiter;

   localparam int NREQ      = 4;
   localparam int MAX_RETRY = 2;
   localparam int BACKOFF   = 8;
   localparam int TIMEOUT   = 1024;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [7*NREQ-1:0] req_addr;
   logic [NREQ-1:0]   rw_m = '0;
   logic [8*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic              err;
   logic [7:0]        rdata;
   logic              m_start;
   logic [6:0]        m_addr;
   logic              m_rw;
   logic [7:0]        m_wdata;
   logic              m_abort;
   logic              m_done = 1'b0;
   logic              m_error = 1'b0;
   logic [7:0]        m_rdata = 8'h00;

   logic [6:0] addr_m [NREQ];
   logic [7:0] wd_m   [NREQ];

   int total = 0;
   int bad = 0;
   int ptr_m = NREQ - 1;
   int exp_win = -1;
   logic [NREQ-1:0] seen_gnt;

   i2c_master_arbiter #(
      .NREQ(NREQ), .MAX_RETRY(MAX_RETRY),
      .BACKOFF(BACKOFF), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .req(req),
      .req_addr(req_addr), .req_rw(rw_m),
      .req_wdata(req_wdata), .gnt(gnt), .done(done),
      .err(err), .rdata(rdata), .m_start(m_start),
      .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
      .m_abort(m_abort), .m_done(m_done),
      .m_error(m_error), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Pack per-requester fields onto the flat request buses
   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_addr[7*i +: 7]  = addr_m[i];
         req_wdata[8*i +: 8] = wd_m[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int predict();
      for (int k = 1; k <= NREQ; k++)
         if (req[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
      return -1;
   endfunction

   task automatic fields(input int w);
      chk("gnt", 32'(gnt), 32'(1 << w));
      chk("m_addr", 32'(m_addr), 32'(addr_m[w]));
      chk("m_rw", 32'(m_rw), 32'(rw_m[w]));
      chk("m_wdata", 32'(m_wdata), 32'(wd_m[w]));
   endtask

   // One whole transaction: dly cycles from m_start to m_done,
   // m_error on the first nerr attempts, or no m_done at all (tmo).
   task automatic serve(input int dly, input int nerr,
                        input logic [7:0] rd, input bit tmo,
                        input bit rearm);
      int w;
      int att;
      bit er;
      bit fin;
      if (exp_win < 0) exp_win = predict();
      w = exp_win;
      chk("pending", 32'(w >= 0), 32'd1);
      if (w < 0) w = 0;
      for (int k = 0; k < 64 && m_start !== 1'b1; k++)
         @(negedge clk);
      chk("m_start", 32'(m_start), 32'd1);
      seen_gnt = gnt;
      fields(w);
      att = 0;
      fin = 1'b0;
      while (!fin) begin
         if (tmo) begin
            repeat (TIMEOUT) @(negedge clk);
            chk("abort_early", 32'(m_abort), 32'd0);
            @(negedge clk);
            chk("abort", 32'(m_abort), 32'd1);
            chk("tmo_done", 32'(done), 32'(1 << w));
            chk("tmo_err", 32'(err), 32'd1);
            fin = 1'b1;
         end else begin
            repeat (dly) @(negedge clk);
            er = (att < nerr);
            m_done  = 1'b1;
            m_error = er;
            m_rdata = rd;
            @(negedge clk);
            m_done  = 1'b0;
            m_error = 1'b0;
            m_rdata = 8'($urandom);
            if (er && att < MAX_RETRY) begin
               chk("retry_nodone", 32'(done), 32'd0);
               repeat (BACKOFF - 1) @(negedge clk);
               chk("backoff_quiet", 32'(m_start), 32'd0);
               @(negedge clk);
               chk("restart", 32'(m_start), 32'd1);
               fields(w);
               att++;
            end else begin
               chk("done", 32'(done), 32'(1 << w));
               chk("err", 32'(err), 32'(er));
               chk("rdata", 32'(rdata),
                   32'((!er && rw_m[w]) ? rd : 8'h00));
               chk("no_abort", 32'(m_abort), 32'd0);
               fin = 1'b1;
            end
         end
      end
      req[w] = 1'b0;
      ptr_m = w;
      exp_win = (req != '0) ? predict() : -1;
      @(negedge clk);
      chk("gnt_off", 32'(gnt), 32'd0);
      chk("done_off", 32'(done), 32'd0);
      @(negedge clk);
      if (rearm) req[w] = 1'b1;
   endtask

   task automatic drain();
      while (req != '0) serve(1, 0, 8'h00, 1'b0, 1'b0);
   endtask

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int order [5];
      order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < NREQ; i++) begin
         addr_m[i] = 7'h00;
         wd_m[i]   = 8'h00;
      end
      #1 rst = 1'b0;
      #2;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_start", 32'(m_start), 32'd0);
      chk("rst_abort", 32'(m_abort), 32'd0);
      chk("rst_addr", 32'(m_addr), 32'd0);
      chk("rst_wdata", 32'(m_wdata), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
      chk("idle_mdone_done", 32'(done), 32'd0);
      chk("idle_mdone_gnt", 32'(gnt), 32'd0);
      @(negedge clk);
      chk("idle_mdone_start", 32'(m_start), 32'd0);

      for (int i = 0; i < NREQ; i++) begin
         addr_m[i] = 7'h10 + 7'(i);
         wd_m[i]   = 8'h20 + 8'(i);
         rw_m[i]   = 1'(i);
      end
      req = '1;
      for (int n = 0; n < 5; n++) begin
         serve(1, 0, 8'h5A, 1'b0, n < 4);
         chk("rr_order", 32'(seen_gnt), 32'(1 << order[n]));
      end
      drain();

      addr_m[0] = 7'h50; rw_m[0] = 1'b0; wd_m[0] = 8'hA5;
      req = 4'b0001;
      @(negedge clk);
      chk("wr_latency", 32'(m_start), 32'd1);
      serve(20, 0, 8'h77, 1'b0, 1'b0);

      addr_m[2] = 7'h2C; rw_m[2] = 1'b1; wd_m[2] = 8'h00;
      req = 4'b0100;
      serve(5, 0, 8'h93, 1'b0, 1'b0);

      addr_m[1] = 7'h31; rw_m[1] = 1'b1; wd_m[1] = 8'h0F;
      req = 4'b0010;
      serve(4, 2, 8'hC3, 1'b0, 1'b0);
      req = 4'b0010;
      serve(3, 3, 8'hC3, 1'b0, 1'b0);

      req = 4'b0110;
      serve(0, 0, 8'h00, 1'b1, 1'b0);
      drain();

      addr_m[0] = 7'h44; rw_m[0] = 1'b1;
      req = 4'b0001;
      serve(TIMEOUT, 0, 8'h3C, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NREQ; i++) begin
            addr_m[i] = 7'($urandom);
            wd_m[i]   = 8'($urandom);
            rw_m[i]   = 1'($urandom);
         end
         req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         while (req != '0)
            serve($urandom_range(1, 25), $urandom_range(0, 3),
                  8'($urandom), 1'b0, 1'b0);
      end

      addr_m[0] = 7'h12; rw_m[0] = 1'b0; wd_m[0] = 8'hEE;
      addr_m[3] = 7'h63; rw_m[3] = 1'b1; wd_m[3] = 8'h00;
      req = 4'b0001;
      @(negedge clk);
      chk("pre_rst_start", 32'(m_start), 32'd1);
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("arst_gnt", 32'(gnt), 32'd0);
      chk("arst_start", 32'(m_start), 32'd0);
      chk("arst_addr", 32'(m_addr), 32'd0);
      chk("arst_rw", 32'(m_rw), 32'd0);
      chk("arst_wdata", 32'(m_wdata), 32'd0);
      chk("arst_abort", 32'(m_abort), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_err", 32'(err), 32'd0);
      req = 4'b1000;
      ptr_m = NREQ - 1;
      exp_win = -1;
      @(negedge clk);
      rst = 1'b1;
      serve(6, 0, 8'h81, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
